// File: rtl/sys_defs.sv
// Shared fetch-path types: instruction word, fetch FSM states and
// the instruction-queue entry bundle.
package sys_defs;

    localparam int XLEN = 32;

    typedef logic [31:0] INST;

    typedef enum logic [1:0] {
        F_REQ,
        F_WAIT,
        F_HALT
    } FETCH_STATE;

    typedef struct packed {
        INST             inst;
        logic [XLEN-1:0] pc;
    } FQ_ENTRY;

endpackage

// File: rtl/fetch_unit_inst_fifo.sv
// Circular instruction queue holding fetched {inst, pc} entries.
// Head entry is presented combinationally; reads as zero when empty.
module inst_fifo
    import sys_defs::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  FQ_ENTRY       push_data,
    input  logic          pop,
    output FQ_ENTRY       head_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    FQ_ENTRY       mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + AW'(1);
            if (do_pop)  head <= head + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !clear && !reset) mem[tail] <= push_data;
    end

    assign head_data = empty ? '0 : mem[head];

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: sequential PC generation, single-outstanding I-cache
// requests, instruction buffering, flush/redirect and halt handling.
module fetch_unit
    import sys_defs::*;
#(
    parameter int              FQ_DEPTH = 8,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            dispatch_stall,
    input  logic            flush,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            out_valid,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;

    FETCH_STATE      state;
    FETCH_STATE      next_state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic            drop_rsp;
    logic            halt_seen;
    logic [CW-1:0]   count;
    logic            full;
    logic            empty;
    logic            pop;
    logic            push;
    logic            fire;
    FQ_ENTRY         head;
    FQ_ENTRY         wr_entry;

    assign pop  = (count != '0) && !dispatch_stall;
    assign fire = imem_req && imem_gnt;
    assign push = (state == F_WAIT) && imem_rsp_valid && !drop_rsp && !flush;

    always_ff @(posedge clock) begin
        if (reset) state <= F_REQ;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            F_REQ: begin
                if (flush)     next_state = F_REQ;
                else if (fire) next_state = F_WAIT;
                else if (halt) next_state = F_HALT;
            end
            F_WAIT: begin
                if (imem_rsp_valid)
                    next_state = (!flush && (halt_seen || halt)) ? F_HALT : F_REQ;
            end
            F_HALT: begin
                if (flush) next_state = F_REQ;
            end
            default: next_state = F_REQ;
        endcase
    end

    // A request needs a free slot after this cycle's pop; none issues during flush.
    always_comb begin
        imem_req = 1'b0;
        if (state == F_REQ && !reset && !flush) imem_req = !full || pop;
    end

    assign imem_addr = fetch_pc;

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc  <= RESET_PC;
            req_pc    <= '0;
            drop_rsp  <= 1'b0;
            halt_seen <= 1'b0;
        end else begin
            if (flush) begin
                fetch_pc  <= {redirect_pc[XLEN-1:2], 2'b00};
                halt_seen <= 1'b0;
            end else begin
                if (fire) begin
                    req_pc   <= fetch_pc;
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (halt) halt_seen <= 1'b1;
            end
            if (state == F_WAIT) begin
                if (imem_rsp_valid) drop_rsp <= 1'b0;
                else if (flush)     drop_rsp <= 1'b1;
            end
        end
    end

    assign wr_entry.inst = imem_rsp_data;
    assign wr_entry.pc   = req_pc;

    inst_fifo #(
        .DEPTH(FQ_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .clear    (flush),
        .push     (push),
        .push_data(wr_entry),
        .pop      (pop),
        .head_data(head),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    assign out_valid = !empty;
    assign out_inst  = head.inst;
    assign out_pc    = head.pc;

endmodule
